// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: Moore control FSM sequencing a multicycle RV32I datapath
// Inputs:  clk, rst (async, active high), op_code (IR[6:0]), cond_true (branch decision),
//          mem_ready (unified memory completes the current request this cycle)
// Outputs: mem_req/mem_write/adr_src (memory port), ir_write/pc_write/reg_write (enables),
//          alu_src_a/alu_src_b/alu_op/result_src (datapath muxes), imm_src (immediate format),
//          ld_st_op (size decode enable), instr_retired (last cycle pulse), illegal_op (trap)
module multicycle_ctrl_fsm #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op_code,
  input  logic       cond_true,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic       ld_st_op,
  output logic       instr_retired,
  output logic       illegal_op
);
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXER    = 4'd6,
    S_EXEI    = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_JAL     = 4'd10,
    S_JALR    = 4'd11,
    S_JALR_PC = 4'd12,
    S_LUI     = 4'd13,
    S_AUIPC   = 4'd14,
    S_TRAP    = 4'd15
  } state_t;
  state_t state, next;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= state_t'(RESET_STATE);
    else state <= next;
  assign imm_src = (op_code == 7'b0100011) ? 3'b001 :
                   (op_code == 7'b1100011) ? 3'b010 :
                   (op_code == 7'b0110111 || op_code == 7'b0010111) ? 3'b011 :
                   (op_code == 7'b1101111) ? 3'b100 : 3'b000;
  always_comb begin
    next          = S_FETCH;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    result_src    = 2'b00;
    ld_st_op      = 1'b0;
    instr_retired = 1'b0;
    illegal_op    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        next       = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op_code)
          7'b0000011, 7'b0100011: next = S_MEMADR;
          7'b0110011:             next = S_EXER;
          7'b0010011:             next = S_EXEI;
          7'b1100011:             next = S_BRANCH;
          7'b1101111:             next = S_JAL;
          7'b1100111:             next = S_JALR;
          7'b0110111:             next = S_LUI;
          7'b0010111:             next = S_AUIPC;
          default:                next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        next      = (op_code == 7'b0100011) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req  = 1'b1;
        adr_src  = 1'b1;
        ld_st_op = 1'b1;
        next     = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write     = 1'b1;
        result_src    = 2'b01;
        ld_st_op      = 1'b1;
        instr_retired = 1'b1;
      end
      S_MEMWR: begin
        mem_req       = 1'b1;
        mem_write     = 1'b1;
        adr_src       = 1'b1;
        ld_st_op      = 1'b1;
        instr_retired = mem_ready;
        next          = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        next      = S_ALUWB;
      end
      S_EXEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        next      = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        next      = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        next      = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 2'b10;
        alu_op        = 2'b01;
        pc_write      = cond_true;
        instr_retired = 1'b1;
      end
      // alu_out holds the jump target from decode; the ALU now forms old_pc+4 for rd
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        next      = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        next      = S_JALR_PC;
      end
      S_JALR_PC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        next      = S_ALUWB;
      end
      S_TRAP: begin
        illegal_op = 1'b1;
        next       = S_TRAP;
      end
      default: next = S_FETCH;
    endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: directed self-checking bench for multicycle_ctrl_fsm
module tb_multicycle_ctrl_fsm;
  logic clk = 1'b0, rst = 1'b1, cond_true = 1'b0, mem_ready = 1'b0;
  logic [6:0] op_code = 7'b0110011;
  logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, ld_st_op, instr_retired, illegal_op;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [2:0] imm_src;
  logic [16:0] outs;
  int checks = 0, failures = 0;
  multicycle_ctrl_fsm dut (
    .clk(clk), .rst(rst), .op_code(op_code), .cond_true(cond_true), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .imm_src(imm_src), .ld_st_op(ld_st_op),
    .instr_retired(instr_retired), .illegal_op(illegal_op)
  );
  always #5 clk = ~clk;
  assign outs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, alu_src_a,
                 alu_src_b, alu_op, result_src, ld_st_op, instr_retired, illegal_op};
  function automatic logic [16:0] mk(input logic mr, mw, as, iw, pw, rw, input logic [1:0] a, b, op, rs,
                                     input logic ls, ir, il);
    return {mr, mw, as, iw, pw, rw, a, b, op, rs, ls, ir, il};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // apply inputs at the falling edge, check just after, then wait out the cycle
  task automatic cyc(input string tag, input logic mr, input logic ct, input logic [16:0] exp);
    mem_ready = mr;
    cond_true = ct;
    #1;
    chk(tag, {15'd0, outs}, {15'd0, exp});
    @(negedge clk);
  endtask
  logic [16:0] f_wait, f_go, dec, exer, exei, aluwb, madr, mrd, mwb, mwr_w, mwr_go, jal, jalr, jalr_pc, lui, auipc, trap;
  initial begin
    f_wait  = mk(1,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,0,0);
    f_go    = mk(1,0,0,1,1,0,2'b00,2'b10,2'b00,2'b10,0,0,0);
    dec     = mk(0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0,0,0);
    exer    = mk(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,0,0);
    exei    = mk(0,0,0,0,0,0,2'b10,2'b01,2'b10,2'b00,0,0,0);
    aluwb   = mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0,1,0);
    madr    = mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0,0,0);
    mrd     = mk(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,1,0,0);
    mwb     = mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b01,1,1,0);
    mwr_w   = mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,1,0,0);
    mwr_go  = mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,1,1,0);
    jal     = mk(0,0,0,0,1,0,2'b01,2'b10,2'b00,2'b00,0,0,0);
    jalr    = mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0,0,0);
    jalr_pc = mk(0,0,0,0,1,0,2'b01,2'b10,2'b00,2'b00,0,0,0);
    lui     = mk(0,0,0,0,0,0,2'b11,2'b01,2'b00,2'b00,0,0,0);
    auipc   = mk(0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0,0,0);
    trap    = mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,1);
    @(negedge clk);
    cyc("reset", 0, 0, f_wait);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc("fetch_wait", 0, 0, f_wait);
    cyc("fetch_go", 1, 0, f_go);
    cyc("r_dec", 1, 0, dec);
    chk("imm_r", {29'd0, imm_src}, 32'd0);
    cyc("r_exe", 1, 0, exer);
    cyc("r_wb", 1, 0, aluwb);
    cyc("r2_fetch", 1, 0, f_go);
    cyc("r2_dec", 1, 0, dec);
    cyc("r2_exe", 1, 0, exer);
    cyc("r2_wb", 1, 0, aluwb);
    op_code = 7'b0010011;
    cyc("i_fetch", 1, 0, f_go);
    cyc("i_dec", 1, 0, dec);
    cyc("i_exe", 1, 0, exei);
    cyc("i_wb", 1, 0, aluwb);
    op_code = 7'b0000011;
    cyc("ld_fetch", 1, 0, f_go);
    cyc("ld_dec", 1, 0, dec);
    chk("imm_ld", {29'd0, imm_src}, 32'd0);
    cyc("ld_adr", 1, 0, madr);
    cyc("ld_rd_w0", 0, 0, mrd);
    cyc("ld_rd_w1", 0, 0, mrd);
    cyc("ld_rd_go", 1, 0, mrd);
    cyc("ld_wb", 1, 0, mwb);
    op_code = 7'b0100011;
    cyc("st_fetch", 1, 0, f_go);
    cyc("st_dec", 1, 0, dec);
    chk("imm_st", {29'd0, imm_src}, 32'd1);
    cyc("st_adr", 1, 0, madr);
    cyc("st_wr", 1, 0, mwr_go);
    op_code = 7'b1100011;
    cyc("br0_fetch", 1, 0, f_go);
    cyc("br0_dec", 1, 0, dec);
    chk("imm_br", {29'd0, imm_src}, 32'd2);
    cyc("br0_br", 1, 0, mk(0,0,0,0,0,0,2'b10,2'b00,2'b01,2'b00,0,1,0));
    cyc("br1_fetch", 1, 1, f_go);
    cyc("br1_dec", 1, 1, dec);
    cyc("br1_br", 1, 1, mk(0,0,0,0,1,0,2'b10,2'b00,2'b01,2'b00,0,1,0));
    op_code = 7'b1100111;
    cyc("jalr_fetch", 1, 0, f_go);
    cyc("jalr_dec", 1, 0, dec);
    chk("imm_jalr", {29'd0, imm_src}, 32'd0);
    cyc("jalr_exe", 1, 0, jalr);
    cyc("jalr_pc", 1, 0, jalr_pc);
    cyc("jalr_wb", 1, 0, aluwb);
    op_code = 7'b1101111;
    cyc("jal_fetch", 1, 0, f_go);
    cyc("jal_dec", 1, 0, dec);
    chk("imm_jal", {29'd0, imm_src}, 32'd4);
    cyc("jal_exe", 1, 0, jal);
    cyc("jal_wb", 1, 0, aluwb);
    op_code = 7'b0110111;
    cyc("lui_fetch", 1, 0, f_go);
    cyc("lui_dec", 1, 0, dec);
    chk("imm_lui", {29'd0, imm_src}, 32'd3);
    cyc("lui_exe", 1, 0, lui);
    cyc("lui_wb", 1, 0, aluwb);
    op_code = 7'b0010111;
    cyc("auipc_fetch", 1, 0, f_go);
    cyc("auipc_dec", 1, 0, dec);
    cyc("auipc_exe", 1, 0, auipc);
    cyc("auipc_wb", 1, 0, aluwb);
    op_code = 7'b1111111;
    cyc("ill_fetch", 1, 0, f_go);
    cyc("ill_dec", 1, 0, dec);
    chk("imm_ill", {29'd0, imm_src}, 32'd0);
    for (int i = 0; i < 10; i++) cyc("trap", 1, i[0], trap);
    rst = 1'b1;
    cyc("trap_rst", 0, 0, f_wait);
    rst = 1'b0;
    op_code = 7'b0100011;
    cyc("st2_fetch", 1, 0, f_go);
    cyc("st2_dec", 1, 0, dec);
    cyc("st2_adr", 1, 0, madr);
    cyc("st2_wr_w", 0, 0, mwr_w);
    #2 rst = 1'b1;
    #1 chk("async_rst", {15'd0, outs}, {15'd0, f_wait});
    @(negedge clk);
    rst = 1'b0;
    cyc("post_rst", 0, 0, f_wait);
    cyc("post_go", 1, 0, f_go);
    cyc("post_dec", 1, 0, dec);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
